// File: rtl/char_jump_ctrl_pkg.sv
// Shared types and widths for the character vertical-motion controller.
// Pure declarations; no timing or flow control.
package char_jump_ctrl_pkg;

    localparam int Y_W       = 9;
    localparam int VEL_W     = 6;
    localparam int SUM_W     = Y_W + 1;
    localparam int CHAR_SIZE = 16;

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_RISE   = 2'd1,
        ST_FALL   = 2'd2,
        ST_LAND   = 2'd3
    } jump_state_t;

    function automatic logic signed [SUM_W-1:0] sext_vel(input logic signed [VEL_W-1:0] v);
        return {{(SUM_W-VEL_W){v[VEL_W-1]}}, v};
    endfunction

endpackage

// File: rtl/char_jump_ctrl_req_latch.sv
// Jump button rising-edge detector whose request is held until the next frame_tick.
// Edge is seen combinationally in its own cycle; latch clears on every tick; no backpressure.
module char_jump_ctrl_req_latch (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic frame_tick,
    input  logic btn_jump,
    output logic req
);

    logic btn_q;
    logic held;
    logic btn_rise;

    assign btn_rise = btn_jump & ~btn_q;
    // A press landing on the tick cycle itself still counts for that tick.
    assign req      = held | btn_rise;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            btn_q <= 1'b0;
            held  <= 1'b0;
        end else begin
            btn_q <= btn_jump;
            if (frame_tick) begin
                held <= 1'b0;
            end else if (btn_rise) begin
                held <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/char_jump_ctrl.sv
// Vertical-motion FSM: launches, gravity, variable-height cut, ceiling, landing and floor clamps.
// All outputs registered, updated one cycle after a frame_tick; no backpressure.
module char_jump_ctrl
    import char_jump_ctrl_pkg::*;
#(
    parameter logic [Y_W-1:0]   START_Y    = 9'd34,
    parameter logic [Y_W-1:0]   FLOOR_Y    = 9'd200,
    parameter logic [VEL_W-1:0] JUMP_V     = 6'd6,
    parameter logic [VEL_W-1:0] SPRING_V   = 6'd10,
    parameter logic [VEL_W-1:0] GRAVITY    = 6'd1,
    parameter logic [VEL_W-1:0] MAX_FALL_V = 6'd8,
    parameter logic [3:0]       GRAV_DIV   = 4'd2,
    parameter logic [VEL_W-1:0] CUT_V      = 6'd2
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic                    frame_tick,
    input  logic                    btn_jump,
    input  logic                    spring_jump,
    input  logic                    landed,
    input  logic [Y_W-1:0]          land_Y,
    input  logic                    ceiling_hit,
    output logic [Y_W-1:0]          char_Y,
    output logic signed [VEL_W-1:0] vy,
    output logic                    airborne,
    output logic                    jump_start,
    output logic [1:0]              jump_state
);

    localparam logic signed [VEL_W-1:0] JUMP_VY   = -$signed(JUMP_V);
    localparam logic signed [VEL_W-1:0] SPRING_VY = -$signed(SPRING_V);
    localparam logic signed [VEL_W-1:0] CUT_VY    = -$signed(CUT_V);
    localparam logic signed [VEL_W-1:0] MAX_FALL  = $signed(MAX_FALL_V);

    jump_state_t state;
    logic [3:0]  grav_cnt;
    logic        req;

    logic signed [SUM_W-1:0] pos_sum;
    logic signed [VEL_W+1:0] vy_grav;
    logic signed [VEL_W-1:0] vy_air;
    logic                    grav_step;
    logic                    sum_neg;
    logic                    sum_floor;

    char_jump_ctrl_req_latch u_req_latch (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .frame_tick (frame_tick),
        .btn_jump   (btn_jump),
        .req        (req)
    );

    assign jump_state = state;

    always_comb begin
        pos_sum   = $signed({1'b0, char_Y}) + sext_vel(vy);
        sum_neg   = pos_sum[SUM_W-1];
        sum_floor = pos_sum >= $signed({1'b0, FLOOR_Y});
        grav_step = (grav_cnt >= (GRAV_DIV - 4'd1));
        vy_grav   = {{2{vy[VEL_W-1]}}, vy} + {2'b00, GRAVITY};
        vy_air    = vy;
        if (grav_step) begin
            if (vy_grav > $signed({2'b00, MAX_FALL_V})) begin
                vy_air = MAX_FALL;
            end else begin
                vy_air = vy_grav[VEL_W-1:0];
            end
        end
        // Releasing the button while still rising fast trims the jump height.
        if (state == ST_RISE && !btn_jump && vy_air < CUT_VY) begin
            vy_air = CUT_VY;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state      <= ST_GROUND;
            char_Y     <= START_Y;
            vy         <= '0;
            airborne   <= 1'b0;
            jump_start <= 1'b0;
            grav_cnt   <= '0;
        end else begin
            jump_start <= 1'b0;
            if (frame_tick) begin
                case (state)
                    ST_GROUND: begin
                        if (spring_jump) begin
                            state      <= ST_RISE;
                            vy         <= SPRING_VY;
                            airborne   <= 1'b1;
                            jump_start <= 1'b1;
                            grav_cnt   <= '0;
                        end else if (req) begin
                            state      <= ST_RISE;
                            vy         <= JUMP_VY;
                            airborne   <= 1'b1;
                            jump_start <= 1'b1;
                            grav_cnt   <= '0;
                        end else if (!landed) begin
                            state    <= ST_FALL;
                            vy       <= '0;
                            airborne <= 1'b1;
                        end
                    end

                    ST_RISE: begin
                        grav_cnt <= grav_step ? 4'd0 : grav_cnt + 4'd1;
                        char_Y   <= sum_neg ? '0 : pos_sum[Y_W-1:0];
                        if (ceiling_hit || sum_neg) begin
                            vy    <= '0;
                            state <= ST_FALL;
                        end else begin
                            vy <= vy_air;
                            if (!vy_air[VEL_W-1]) begin
                                state <= ST_FALL;
                            end
                        end
                    end

                    ST_FALL: begin
                        grav_cnt <= grav_step ? 4'd0 : grav_cnt + 4'd1;
                        if (landed || sum_floor) begin
                            state    <= ST_LAND;
                            char_Y   <= landed ? land_Y : FLOOR_Y;
                            vy       <= '0;
                            airborne <= 1'b0;
                        end else begin
                            char_Y <= sum_neg ? '0 : pos_sum[Y_W-1:0];
                            vy     <= sum_neg ? '0 : vy_air;
                        end
                    end

                    ST_LAND: begin
                        // A spring under the landing spot bounces straight back up.
                        if (spring_jump) begin
                            state      <= ST_RISE;
                            vy         <= SPRING_VY;
                            airborne   <= 1'b1;
                            jump_start <= 1'b1;
                            grav_cnt   <= '0;
                        end else if (landed) begin
                            state    <= ST_GROUND;
                            airborne <= 1'b0;
                        end else begin
                            state    <= ST_FALL;
                            vy       <= '0;
                            airborne <= 1'b1;
                        end
                    end

                    default: begin
                        state    <= ST_GROUND;
                        airborne <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
